// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TAG_START,
        START,
        WAIT_ACK,
        WAIT_DONE
    } arb_state_t;

    // Tag byte sent ahead of a packet is TAG_BASE | owner index.
    localparam logic [7:0] TAG_BASE = 8'hA0;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: rotate requests so ptr sits at bit 0, take the lowest
// set bit, then rotate the winner back into absolute position.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               any
);

    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0]      off;
    logic [IW:0]        sum;

    // Rotate, priority-encode from the bottom, rotate back (modulo NUM_REQ).
    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        off = '0;
        any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IW'(i);
                any = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
        gnt_idx = sum[IW-1:0];
        gnt     = any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte streams.
// A requester owns the transmitter for a whole packet (until in_last).
// Optional feature macro UART_ARB_TAG_EN: prefix each packet with a tag byte
// TAG_BASE | owner index.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          in_valid,
    input  logic [8*NUM_REQ-1:0]        in_data,
    input  logic [NUM_REQ-1:0]          in_last,
    output logic [NUM_REQ-1:0]          in_ready,
    output logic                        tx_start,
    output logic [7:0]                  tx_data,
    input  logic                        tx_busy,
    output logic [idx_w(NUM_REQ)-1:0]   grant,
    output logic                        locked,
    output logic                        err_timeout
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
`ifdef UART_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      ptr_q, grant_q, acc_idx, pick_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_any, locked_q, last_q;
    logic [7:0]         byte_q, tx_data_q, in_byte;
    logic [CW-1:0]      cnt_q;
    logic               accept, xfer_done, tag_phase;

    rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign in_byte     = in_data[{acc_idx, 3'b000} +: 8];
    assign tx_start    = (state_q == START) || (state_q == TAG_START);
    assign tx_data     = tx_data_q;
    assign grant       = grant_q;
    assign locked      = locked_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, accept strobe and handshake decode.
    always_comb begin
        state_d     = state_q;
        in_ready    = '0;
        accept      = 1'b0;
        xfer_done   = 1'b0;
        err_timeout = 1'b0;
        acc_idx     = locked_q ? grant_q : pick_idx;
        case (state_q)
            IDLE: begin
                // While locked only the owner may offer its next byte.
                accept = locked_q ? in_valid[grant_q] : pick_any;
                if (rst) accept = 1'b0;
                if (accept) begin
                    in_ready = locked_q ? (NUM_REQ'(1) << grant_q) : pick_gnt;
                    state_d  = (TAG_EN && !locked_q) ? TAG_START : START;
                end
            end
            TAG_START, START: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (tx_busy) state_d = WAIT_DONE;
                else if (cnt_q == CW'(ACK_TIMEOUT)) begin
                    // No ack: report it and treat the byte as sent.
                    err_timeout = 1'b1;
                    xfer_done   = 1'b1;
                end
            end
            WAIT_DONE: xfer_done = !tx_busy;
            default:   state_d = IDLE;
        endcase
        if (xfer_done) state_d = tag_phase ? START : IDLE;
    end

`ifdef UART_ARB_TAG_EN
    logic tag_q;
    // Tag phase: set on a fresh grant, cleared once the tag byte is out.
    always_ff @(posedge clk) begin
        if (rst)            tag_q <= 1'b0;
        else if (accept)    tag_q <= !locked_q;
        else if (xfer_done) tag_q <= 1'b0;
    end
    assign tag_phase = tag_q;
`else
    assign tag_phase = 1'b0;
`endif

    // Datapath: byte capture, ownership, fairness pointer and ack timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            grant_q   <= '0;
            locked_q  <= 1'b0;
            byte_q    <= 8'h00;
            last_q    <= 1'b0;
            tx_data_q <= 8'h00;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                byte_q    <= in_byte;
                last_q    <= in_last[acc_idx];
                grant_q   <= acc_idx;
                locked_q  <= 1'b1;
                tx_data_q <= (TAG_EN && !locked_q) ? (TAG_BASE | 8'(acc_idx)) : in_byte;
            end
            if (tx_start)                  cnt_q <= CW'(1);
            else if (state_q == WAIT_ACK)  cnt_q <= cnt_q + CW'(1);
            // After the tag byte, the held data byte goes out next.
            if (xfer_done && tag_phase) tx_data_q <= byte_q;
            // Pointer only moves at packet end, to just past the owner.
            if (xfer_done && !tag_phase && last_q) begin
                locked_q <= 1'b0;
                ptr_q    <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level round-robin model, transmitter model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid, in_last, in_ready;
    logic [8*N-1:0] in_data;
    logic           tx_start, tx_busy, locked, err_timeout;
    logic [7:0]     tx_data;
    logic [1:0]     grant;

    uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .grant(grant),
        .locked(locked), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, m_ptr = 0;
    logic [8:0] rq[N][$];
    logic [8:0] mq[N][$];
    int sent_d[$], sent_g[$], start_cyc[$], err_cyc[$], acc_cyc[$];
    int exp_d[$], exp_g[$];
    bit no_ack = 0, abort = 0;
    int bd_min = 1, bd_max = 1, bl_min = 10, bl_max = 10;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_byte(input int r, input logic [7:0] d, input bit last);
        rq[r].push_back({last, d});
        mq[r].push_back({last, d});
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Transmitter model: records each start, then busy after a delay.
    initial begin : xmtr
        logic [7:0] held;
        int d, l;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                sent_d.push_back(int'(tx_data));
                sent_g.push_back(int'(grant));
                start_cyc.push_back(cyc);
                if (!no_ack) begin
                    held = tx_data;
                    d = $urandom_range(bd_max, bd_min);
                    l = $urandom_range(bl_max, bl_min);
                    repeat (d) @(negedge clk);
                    tx_busy = 1'b1;
                    repeat (l) begin
                        @(negedge clk);
                        if (!abort) chk("tx_data_hold", tx_data, held);
                    end
                    tx_busy = 1'b0;
                end
            end
        end
    end

    initial begin : mon
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) chk("start_single_cycle", prev, 0);
            prev = tx_start;
            if (err_timeout) err_cyc.push_back(cyc);
        end
    end

    // Requester model: each requester offers the head of its byte queue.
    initial begin : feeder
        logic [N-1:0] acc;
        acc = '0; in_valid = '0; in_data = '0; in_last = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (acc[i] && rq[i].size() > 0) rq[i].delete(0);
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0) begin
                    in_valid[i] = 1'b1;
                    in_data[8*i +: 8] = rq[i][0][7:0];
                    in_last[i] = rq[i][0][8];
                end else begin
                    in_valid[i] = 1'b0;
                    in_data[8*i +: 8] = 8'h00;
                    in_last[i] = 1'b0;
                end
            end
            #1;
            acc = rst ? '0 : (in_valid & in_ready);
            if (acc != '0) acc_cyc.push_back(cyc);
            if (in_ready != '0) begin
                chk("in_ready_onehot", $onehot(in_ready), 1);
                if (locked) chk("in_ready_owner", in_ready, 1 << grant);
            end
        end
    end

    // Expected stream: serve whole packets, searching from m_ptr with wrap.
    task automatic run_case(input string name, input int budget);
        bit done;
        logic [8:0] b;
        int w;
        exp_d.delete(); exp_g.delete();
        while (1) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && mq[(m_ptr + k) % N].size() > 0) w = (m_ptr + k) % N;
            if (w < 0) break;
`ifdef UART_ARB_TAG_EN
            exp_d.push_back(8'hA0 | w); exp_g.push_back(w);
`endif
            do begin
                b = mq[w].pop_front();
                exp_d.push_back(int'(b[7:0]));
                exp_g.push_back(w);
            end while (!b[8]);
            m_ptr = (w + 1) % N;
        end
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (queues_empty() && sent_d.size() >= exp_d.size() && !locked && !tx_busy) done = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk({name, "_done"}, done, 1);
        chk({name, "_count"}, sent_d.size(), exp_d.size());
        for (int k = 0; k < exp_d.size() && k < sent_d.size(); k++) begin
            chk({name, "_data"}, sent_d[k], exp_d[k]);
            chk({name, "_grant"}, sent_g[k], exp_g[k]);
        end
        sent_d.delete(); sent_g.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_tx_start"}, tx_start, 0);
        chk({pfx, "_tx_data"}, tx_data, 8'h00);
        chk({pfx, "_in_ready"}, in_ready, 0);
        chk({pfx, "_err"}, err_timeout, 0);
        chk({pfx, "_grant"}, grant, 0);
        chk({pfx, "_locked"}, locked, 0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_outputs("reset");

        // Single byte from requester 0, ack one cycle after start.
        acc_cyc.delete(); start_cyc.delete();
        add_byte(0, 8'h41, 1'b1);
        run_case("single", 200);
        chk("single_locked", locked, 0);
        chk("single_grant", grant, 0);
        if (acc_cyc.size() > 0 && start_cyc.size() > 0)
            chk("accept_to_start", start_cyc[0] - acc_cyc[0], 1);
        else chk("accept_to_start_seen", 0, 1);

        // Pointer moved past requester 0: requester 1 wins over 0.
        bd_min = 1; bd_max = 3; bl_min = 1; bl_max = 4;
        add_byte(0, 8'h50, 1'b1);
        add_byte(1, 8'h51, 1'b1);
        run_case("ptr_adv", 300);

        // All four contending from ptr 0.
        do_reset();
        add_byte(0, 8'h10, 1'b1); add_byte(0, 8'h10, 1'b1);
        add_byte(1, 8'h11, 1'b1); add_byte(2, 8'h12, 1'b1); add_byte(3, 8'h13, 1'b1);
        run_case("all4", 600);

        // Multi-byte packet from requester 2 is not pre-empted by requester 1.
        add_byte(1, 8'h5B, 1'b1);
        run_case("pre", 200);
        add_byte(2, 8'hC0, 1'b0); add_byte(2, 8'hC1, 1'b0); add_byte(2, 8'hC2, 1'b1);
        add_byte(1, 8'h5A, 1'b1);
        run_case("packet", 600);

        // Transmitter never acks: timeout fires 64 cycles after start.
        no_ack = 1'b1;
        start_cyc.delete(); err_cyc.delete();
        add_byte(0, 8'h77, 1'b1);
        add_byte(3, 8'h88, 1'b1);
        run_case("timeout", 400);
        chk("timeout_pulses", err_cyc.size(), start_cyc.size());
        for (int k = 0; k < err_cyc.size() && k < start_cyc.size(); k++)
            chk("timeout_delay", err_cyc[k] - start_cyc[k], TO);
        no_ack = 1'b0;

        // Reset during the busy phase of a middle byte.
        bd_min = 1; bd_max = 1; bl_min = 20; bl_max = 20;
        add_byte(2, 8'hD0, 1'b0); add_byte(2, 8'hD1, 1'b0); add_byte(2, 8'hD2, 1'b1);
        mq[2].delete();
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (sent_d.size() >= 2 && tx_busy) seen = 1'b1;
        end
        chk("midrst_reached", seen, 1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk_reset_outputs("midrst");
        if (sent_d.size() >= 2) begin
            chk("midrst_b0", sent_d[0], 8'hD0);
            chk("midrst_b1", sent_d[1], 8'hD1);
        end
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (!tx_busy) seen = 1'b1;
        end
        chk("midrst_busy_idle", seen, 1);
        abort = 1'b0;
        m_ptr = 0;
        sent_d.delete(); sent_g.delete();
        bd_min = 1; bd_max = 3; bl_min = 1; bl_max = 6;
        add_byte(3, 8'hE3, 1'b1);
        add_byte(0, 8'hE0, 1'b1);
        run_case("after_rst", 300);

        // Two-byte packet from requester 3 (tag prefix only when enabled).
        add_byte(3, 8'h55, 1'b0); add_byte(3, 8'h66, 1'b1);
        run_case("tag", 300);

        // Randomized packet mixes.
        for (int r = 0; r < 4; r++) begin
            for (int q = 0; q < N; q++) begin
                int np, len;
                np = $urandom_range(2, 0);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(3, 1);
                    for (int k = 0; k < len; k++)
                        add_byte(q, 8'($urandom_range(255, 0)), k == len - 1);
                end
            end
            run_case("random", 3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
